// File: rtl/irq_sequencer.sv
// Fixed-priority interrupt sequencer: edge-latched requests, per-line mask, pulse/ack/RTI handshake, no nesting.
// Latency: event edge k -> pending after k -> Interrupt after k+1; unacked pulses repeat every INT_PULSE+ACK_TIMEOUT cycles.
module irq_sequencer #(
   parameter int N_IRQ       = 4,
   parameter int ID_W        = 2,
   parameter int INT_PULSE   = 2,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] irq_req,
   input  logic             mask_wr,
   input  logic [N_IRQ-1:0] mask_data,
   input  logic             int_ack,
   input  logic             rti_done,
   output logic             Interrupt,
   output logic [ID_W-1:0]  irq_id,
   output logic             in_service,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] mask
);

   localparam int CNT_MAX = (INT_PULSE > ACK_TIMEOUT) ? INT_PULSE : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_ACK,
      S_IN_SERVICE
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_int;
   logic [ID_W-1:0]    r_id;
   logic               r_in_svc;
   logic [N_IRQ-1:0]   r_prev;
   logic [N_IRQ-1:0]   r_pending;
   logic [N_IRQ-1:0]   r_mask;

   logic [N_IRQ-1:0]   w_edge;
   logic [N_IRQ-1:0]   w_elig;
   logic               w_any;
   logic               w_grant;
   logic [ID_W-1:0]    w_sel;
   logic [N_IRQ-1:0]   w_clr;

   assign w_edge  = irq_req & ~r_prev;
   assign w_elig  = r_pending & r_mask;
   assign w_any   = |w_elig;
   assign w_grant = (r_state == S_IDLE) && w_any;

   // Scan from the top so the lowest eligible index wins.
   always_comb begin
      w_sel = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (w_elig[i]) w_sel = ID_W'(i);
      end
   end

   assign w_clr = w_grant ? (N_IRQ'(1) << w_sel) : '0;

   // A fresh edge on the line being granted re-sets its bit, so the event is kept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev    <= '0;
         r_pending <= '0;
         r_mask    <= '1;
      end else begin
         r_prev    <= irq_req;
         r_pending <= (r_pending & ~w_clr) | w_edge;
         if (mask_wr) r_mask <= mask_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_int    <= 1'b0;
         r_id     <= '0;
         r_in_svc <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= S_REQ;
                  r_id    <= w_sel;
                  r_int   <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            S_REQ: begin
               if (int_ack) begin
                  r_state  <= S_IN_SERVICE;
                  r_int    <= 1'b0;
                  r_in_svc <= 1'b1;
               end else if (r_cnt == CNT_W'(INT_PULSE - 1)) begin
                  r_state <= S_WAIT_ACK;
                  r_int   <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_ACK: begin
               if (int_ack) begin
                  r_state  <= S_IN_SERVICE;
                  r_in_svc <= 1'b1;
               end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                  r_state <= S_REQ;
                  r_int   <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_IN_SERVICE: begin
               if (rti_done) begin
                  r_state  <= S_IDLE;
                  r_in_svc <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_int    <= 1'b0;
               r_in_svc <= 1'b0;
            end
         endcase
      end
   end

   assign Interrupt  = r_int;
   assign irq_id     = r_id;
   assign in_service = r_in_svc;
   assign pending    = r_pending;
   assign mask       = r_mask;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: inputs change 1 time unit after each rising edge, outputs are checked there too.
module tb_irq_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] irq_req = '0;
   logic       mask_wr = 1'b0;
   logic [3:0] mask_data = '0;
   logic       int_ack = 1'b0;
   logic       rti_done = 1'b0;
   logic       Interrupt;
   logic [1:0] irq_id;
   logic       in_service;
   logic [3:0] pending;
   logic [3:0] mask;

   int n_chk  = 0;
   int n_fail = 0;

   irq_sequencer #(.N_IRQ(4), .ID_W(2), .INT_PULSE(2), .ACK_TIMEOUT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_req    (irq_req),
      .mask_wr    (mask_wr),
      .mask_data  (mask_data),
      .int_ack    (int_ack),
      .rti_done   (rti_done),
      .Interrupt  (Interrupt),
      .irq_id     (irq_id),
      .in_service (in_service),
      .pending    (pending),
      .mask       (mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ack_and_rti();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      chk("ack_insvc", in_service, 1);
      rti_done = 1'b1;
      tick();
      rti_done = 1'b0;
      chk("rti_idle", in_service, 0);
   endtask

   initial begin
      // 1. reset values
      tick(3);
      chk("rst_int", Interrupt, 0);
      chk("rst_insvc", in_service, 0);
      chk("rst_pend", pending, 4'h0);
      chk("rst_mask", mask, 4'hF);
      chk("rst_id", irq_id, 0);
      rst = 1'b1;
      tick(2);
      chk("idle_int", Interrupt, 0);

      // 2. single request on line 2
      irq_req = 4'b0100;
      tick();
      chk("t2_pend", pending, 4'b0100);
      chk("t2_int0", Interrupt, 0);
      tick();
      chk("t2_int1", Interrupt, 1);
      chk("t2_id", irq_id, 2);
      chk("t2_pclr", pending, 4'h0);
      tick();
      chk("t2_int2", Interrupt, 1);
      tick();
      chk("t2_intlo", Interrupt, 0);
      ack_and_rti();
      tick();
      chk("t2_noretrig", Interrupt, 0);
      chk("t2_nopend", pending, 4'h0);
      irq_req = 4'b0000;
      tick();

      // 3. simultaneous lines 3 and 1: line 1 first, line 3 right after RTI
      irq_req = 4'b1010;
      tick();
      chk("t3_pend", pending, 4'b1010);
      tick();
      chk("t3_int", Interrupt, 1);
      chk("t3_id1", irq_id, 1);
      chk("t3_pend2", pending, 4'b1000);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      chk("t3_ackreq", in_service, 1);
      chk("t3_intdrop", Interrupt, 0);
      rti_done = 1'b1;
      tick();
      rti_done = 1'b0;
      chk("t3_rti", in_service, 0);
      chk("t3_int_r", Interrupt, 0);
      tick();
      chk("t3_int3", Interrupt, 1);
      chk("t3_id3", irq_id, 3);
      chk("t3_pend3", pending, 4'h0);
      ack_and_rti();
      irq_req = 4'b0000;
      tick();

      // 4. masked line 0 stays pending until unmasked
      mask_wr = 1'b1;
      mask_data = 4'b1110;
      tick();
      mask_wr = 1'b0;
      chk("t4_mask", mask, 4'b1110);
      irq_req = 4'b0001;
      tick();
      chk("t4_pend", pending, 4'b0001);
      tick(2);
      chk("t4_noint", Interrupt, 0);
      chk("t4_pendhold", pending, 4'b0001);
      mask_wr = 1'b1;
      mask_data = 4'hF;
      tick();
      mask_wr = 1'b0;
      chk("t4_maskF", mask, 4'hF);
      chk("t4_int_pre", Interrupt, 0);
      tick();
      chk("t4_int", Interrupt, 1);
      chk("t4_id0", irq_id, 0);
      chk("t4_pclr", pending, 4'h0);
      ack_and_rti();
      irq_req = 4'b0000;
      tick();

      // 7. new edge on the granted line in the grant cycle is retained
      mask_wr = 1'b1;
      mask_data = 4'b1011;
      tick();
      mask_wr = 1'b0;
      irq_req = 4'b0100;
      tick();
      irq_req = 4'b0000;
      chk("t7_pend", pending, 4'b0100);
      mask_wr = 1'b1;
      mask_data = 4'hF;
      tick();
      mask_wr = 1'b0;
      irq_req = 4'b0100;
      tick();
      chk("t7_int", Interrupt, 1);
      chk("t7_id", irq_id, 2);
      chk("t7_setwins", pending, 4'b0100);
      irq_req = 4'b0000;
      ack_and_rti();
      tick();
      chk("t7_regrant", Interrupt, 1);
      chk("t7_id2", irq_id, 2);
      chk("t7_pclr", pending, 4'h0);
      ack_and_rti();
      tick();

      // 5. no ack: re-pulse every 17 cycles, ack on the second attempt
      irq_req = 4'b0010;
      tick();
      tick();
      chk("t5_a1", Interrupt, 1);
      tick();
      chk("t5_a1b", Interrupt, 1);
      tick();
      chk("t5_lo0", Interrupt, 0);
      tick(14);
      chk("t5_lo14", Interrupt, 0);
      tick();
      chk("t5_a2", Interrupt, 1);
      chk("t5_id", irq_id, 1);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      chk("t5_insvc", in_service, 1);
      chk("t5_id_hold", irq_id, 1);
      chk("t5_intlo", Interrupt, 0);

      // 6. reset during IN_SERVICE with a pending event
      irq_req = 4'b1010;
      tick();
      chk("t6_pend", pending, 4'b1000);
      chk("t6_insvc", in_service, 1);
      rst = 1'b0;
      #1;
      chk("t6_int", Interrupt, 0);
      chk("t6_insvc0", in_service, 0);
      chk("t6_pend0", pending, 4'h0);
      chk("t6_mask", mask, 4'hF);
      chk("t6_id", irq_id, 0);
      irq_req = 4'b0000;
      tick(2);
      rst = 1'b1;
      tick(5);
      chk("t6_nogrant", Interrupt, 0);
      chk("t6_nopend", pending, 4'h0);
      chk("t6_idle", in_service, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
